// File: rtl/conv_window_mac_pkg.sv
// Shared widths, saturation limits and the final-result saturation helper
// for the convolution MAC stage. Datapath widths derive from BIT_W.
package conv_pkg;
  localparam int BIT_W    = 32;
  localparam int FRAC_DEF = 16;
  localparam int SUM_W    = BIT_W + 4;
  localparam int ACC_W    = BIT_W + 8;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-BIT_W+1){1'b0}}, {(BIT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-BIT_W+1){1'b1}}, {(BIT_W-1){1'b0}}};

  function automatic logic [BIT_W-1:0] sat_to_bit(input logic signed [ACC_W-1:0] acc);
    if (acc > SAT_MAX)      return SAT_MAX[BIT_W-1:0];
    else if (acc < SAT_MIN) return SAT_MIN[BIT_W-1:0];
    else                    return acc[BIT_W-1:0];
  endfunction
endpackage

// File: rtl/conv_window_mac_if.sv
// Window/weight input stream and pixel output stream of the convolution MAC.
interface conv_window_mac_if #(
  parameter int BIT  = 32,
  parameter int N_EL = 9
);
  // Both streams transfer on a rising edge where valid & ready are high;
  // a producer holds valid and its payload stable until that edge.
  logic                in_valid;
  logic                in_ready;
  logic [BIT*N_EL-1:0] window;
  logic [BIT*N_EL-1:0] weight;
  logic [BIT-1:0]      bias;
  logic                out_valid;
  logic                out_ready;
  logic [BIT-1:0]      out_data;
  logic                busy;

  modport master (
    output in_valid, window, weight, bias, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, window, weight, bias, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/conv_window_mac_tree.sv
// Product stage (S1) and adder-tree stage (S2); bias rides alongside the
// data so the accumulate stage sees it aligned with its sum.
module dot_product_tree
  import conv_pkg::*;
#(
  parameter int BIT  = BIT_W,
  parameter int FRAC = FRAC_DEF,
  parameter int N_EL = 9
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic                    stall,
  input  logic                    in_fire,
  input  logic [BIT*N_EL-1:0]     window,
  input  logic [BIT*N_EL-1:0]     weight,
  input  logic [BIT-1:0]          bias,
  output logic                    sum_valid,
  output logic signed [SUM_W-1:0] sum,
  output logic [BIT-1:0]          sum_bias,
  output logic                    busy
);
  logic                    s1_valid;
  logic [BIT-1:0]          bias_s1;
  logic signed [SUM_W-1:0] prod_d [N_EL];
  logic signed [SUM_W-1:0] prod_q [N_EL];
  logic signed [SUM_W-1:0] sum_d;
  logic signed [2*BIT-1:0] a_ext;
  logic signed [2*BIT-1:0] b_ext;

  // Full-width signed product, then an arithmetic shift (floor) kept at SUM_W.
  always_comb begin
    a_ext = '0;
    b_ext = '0;
    for (int e = 0; e < N_EL; e++) begin
      a_ext     = {{BIT{window[e*BIT+BIT-1]}}, window[e*BIT +: BIT]};
      b_ext     = {{BIT{weight[e*BIT+BIT-1]}}, weight[e*BIT +: BIT]};
      prod_d[e] = SUM_W'((a_ext * b_ext) >>> FRAC);
    end
  end

  always_comb begin
    sum_d = '0;
    for (int e = 0; e < N_EL; e++) sum_d = sum_d + prod_q[e];
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      s1_valid  <= 1'b0;
      bias_s1   <= '0;
      prod_q    <= '{default: '0};
      sum_valid <= 1'b0;
      sum       <= '0;
      sum_bias  <= '0;
    end else if (!stall) begin
      s1_valid  <= in_fire;
      bias_s1   <= bias;
      prod_q    <= prod_d;
      sum_valid <= s1_valid;
      sum       <= sum_d;
      sum_bias  <= bias_s1;
    end
  end

  assign busy = s1_valid | sum_valid;
endmodule

// File: rtl/conv_window_mac.sv
// 3-stage convolution MAC: product/adder tree, then channel accumulation,
// bias, saturation and optional ReLU into a held output register.
module conv_window_mac
  import conv_pkg::*;
#(
  parameter int BIT     = BIT_W,
  parameter int FRAC    = FRAC_DEF,
  parameter int F_ROW   = 3,
  parameter int F_COL   = 3,
  parameter int CHANNEL = 1,
  parameter int RELU    = 1
) (
  input logic              clk,
  input logic              rst_,
  conv_window_mac_if.slave bus
);
  localparam int N_EL = F_ROW * F_COL;
  localparam int CW   = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;

  logic                    stall;
  logic                    in_fire;
  logic                    sum_valid;
  logic                    tree_busy;
  logic signed [SUM_W-1:0] sum;
  logic [BIT-1:0]          sum_bias;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] sum_ext;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_d;
  logic [CW-1:0]           ch_cnt;
  logic                    last_ch;
  logic [BIT-1:0]          result;
  logic                    out_valid_q;
  logic [BIT-1:0]          out_data_q;

  // A held, unaccepted result freezes every stage so nothing is overwritten.
  assign stall   = out_valid_q & ~bus.out_ready;
  assign in_fire = bus.in_valid & ~stall;

  dot_product_tree #(.BIT(BIT), .FRAC(FRAC), .N_EL(N_EL)) u_tree (
    .clk       (clk),
    .rst_      (rst_),
    .stall     (stall),
    .in_fire   (in_fire),
    .window    (bus.window),
    .weight    (bus.weight),
    .bias      (bus.bias),
    .sum_valid (sum_valid),
    .sum       (sum),
    .sum_bias  (sum_bias),
    .busy      (tree_busy)
  );

  assign bias_ext = {{(ACC_W-BIT){sum_bias[BIT-1]}}, sum_bias};
  assign sum_ext  = {{(ACC_W-SUM_W){sum[SUM_W-1]}}, sum};

  always_comb begin
    last_ch = (ch_cnt == CW'(CHANNEL - 1));
    acc_d   = ((ch_cnt == '0) ? bias_ext : acc) + sum_ext;
    result  = sat_to_bit(acc_d);
    if ((RELU != 0) && result[BIT-1]) result = '0;
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      ch_cnt      <= '0;
      acc         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (!stall) begin
      // Not stalled means the held result (if any) is consumed this edge.
      out_valid_q <= sum_valid & last_ch;
      if (sum_valid) begin
        acc    <= acc_d;
        ch_cnt <= last_ch ? '0 : ch_cnt + CW'(1);
        if (last_ch) out_data_q <= result;
      end
    end
  end

  assign bus.in_ready  = ~stall;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = tree_busy | (ch_cnt != '0) | out_valid_q;
endmodule

// File: tb/tb_conv_window_mac.sv
// Scoreboard bench for conv_window_mac: three instances (CHANNEL/RELU = 1/0,
// 1/1, 3/0) driven with directed and random beats against a fixed-point model.
module tb_conv_window_mac;
  localparam int N_EL = 9;
  localparam int DW   = 32 * N_EL;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          iv   [3];
  logic [DW-1:0] wn   [3];
  logic [DW-1:0] wt   [3];
  logic [31:0]   bs   [3];
  logic          ordy [3];
  logic          ir   [3];
  logic          ov   [3];
  logic          bsy  [3];
  logic [31:0]   od   [3];

  conv_window_mac_if #(.BIT(32), .N_EL(N_EL)) if0 ();
  conv_window_mac_if #(.BIT(32), .N_EL(N_EL)) if1 ();
  conv_window_mac_if #(.BIT(32), .N_EL(N_EL)) if2 ();

  assign if0.in_valid = iv[0]; assign if0.window = wn[0]; assign if0.weight = wt[0];
  assign if0.bias = bs[0];     assign if0.out_ready = ordy[0];
  assign ir[0] = if0.in_ready; assign ov[0] = if0.out_valid; assign od[0] = if0.out_data;
  assign bsy[0] = if0.busy;

  assign if1.in_valid = iv[1]; assign if1.window = wn[1]; assign if1.weight = wt[1];
  assign if1.bias = bs[1];     assign if1.out_ready = ordy[1];
  assign ir[1] = if1.in_ready; assign ov[1] = if1.out_valid; assign od[1] = if1.out_data;
  assign bsy[1] = if1.busy;

  assign if2.in_valid = iv[2]; assign if2.window = wn[2]; assign if2.weight = wt[2];
  assign if2.bias = bs[2];     assign if2.out_ready = ordy[2];
  assign ir[2] = if2.in_ready; assign ov[2] = if2.out_valid; assign od[2] = if2.out_data;
  assign bsy[2] = if2.busy;

  conv_window_mac #(.CHANNEL(1), .RELU(0)) u0 (.clk(clk), .rst_(rst), .bus(if0.slave));
  conv_window_mac #(.CHANNEL(1), .RELU(1)) u1 (.clk(clk), .rst_(rst), .bus(if1.slave));
  conv_window_mac #(.CHANNEL(3), .RELU(0)) u2 (.clk(clk), .rst_(rst), .bus(if2.slave));

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] exp_q2[$];

  // Reference model state: partial accumulation per instance.
  longint      m_acc   [3];
  int          m_cnt   [3];
  int          ch_of   [3];
  bit          relu_of [3];
  bit          ovr_en  [3];
  logic [31:0] ovr_val [3];
  bit          rnd_stall_on = 1'b0;

  task automatic check(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s u%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  function automatic int q_size(input int k);
    case (k)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  task automatic push_exp(input int k, input logic [31:0] v);
    case (k)
      0:       exp_q0.push_back(v);
      1:       exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endtask

  task automatic peek_exp(input int k, output logic [31:0] v);
    case (k)
      0:       v = exp_q0[0];
      1:       v = exp_q1[0];
      default: v = exp_q2[0];
    endcase
  endtask

  task automatic pop_exp(input int k, output logic [31:0] v);
    case (k)
      0:       v = exp_q0.pop_front();
      1:       v = exp_q1.pop_front();
      default: v = exp_q2.pop_front();
    endcase
  endtask

  // Sign-extend the low w bits of v (models a w-bit two's complement register).
  function automatic longint wrapw(input longint v, input int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

  function automatic longint beat_sum(input logic [DW-1:0] win, input logic [DW-1:0] wgt);
    longint s = 0;
    for (int e = 0; e < N_EL; e++) begin
      longint a = longint'($signed(win[e*32 +: 32]));
      longint b = longint'($signed(wgt[e*32 +: 32]));
      s += wrapw((a * b) >>> 16, 36);
    end
    return wrapw(s, 36);
  endfunction

  task automatic model_accept(input int k, input logic [DW-1:0] win,
                              input logic [DW-1:0] wgt, input logic [31:0] b);
    logic [31:0] res;
    if (m_cnt[k] == 0) m_acc[k] = longint'($signed(b));
    m_acc[k] += beat_sum(win, wgt);
    m_cnt[k]++;
    if (m_cnt[k] == ch_of[k]) begin
      if (m_acc[k] > 64'sd2147483647)       res = 32'h7FFFFFFF;
      else if (m_acc[k] < -64'sd2147483648) res = 32'h80000000;
      else                                  res = m_acc[k][31:0];
      if (relu_of[k] && res[31]) res = 32'h0;
      push_exp(k, ovr_en[k] ? ovr_val[k] : res);
      ovr_en[k] = 1'b0;
      m_cnt[k]  = 0;
    end
  endtask

  task automatic drive_beat(input int k, input logic [DW-1:0] win,
                            input logic [DW-1:0] wgt, input logic [31:0] b);
    int waited = 0;
    @(negedge clk);
    iv[k] = 1'b1; wn[k] = win; wt[k] = wgt; bs[k] = b;
    #1;
    while (!ir[k]) begin
      @(negedge clk); #1;
      waited++;
      if (waited > 2000) begin
        n_checks++; n_err++;
        $display("FAIL in_ready_timeout u%0d: got stalled expected accept", k);
        iv[k] = 1'b0;
        return;
      end
    end
    @(posedge clk);
    model_accept(k, win, wgt, b);
  endtask

  task automatic idle(input int k);
    @(negedge clk);
    iv[k] = 1'b0;
  endtask

  task automatic check_reset_vals();
    for (int k = 0; k < 3; k++) begin
      check("rst_out_valid", k, 32'(ov[k]), 32'd0);
      check("rst_out_data", k, od[k], 32'd0);
      check("rst_busy", k, 32'(bsy[k]), 32'd0);
      check("rst_in_ready", k, 32'(ir[k]), 32'd1);
    end
  endtask

  task automatic drain();
    int cnt = 0;
    while ((q_size(0) + q_size(1) + q_size(2)) != 0 && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    repeat (4) @(negedge clk);
    check("drain_pending", 0, 32'(q_size(0) + q_size(1) + q_size(2)), 32'd0);
  endtask

  function automatic logic [DW-1:0] rnd_vec(input bit big);
    logic [DW-1:0] v;
    logic [31:0]   x;
    for (int e = 0; e < N_EL; e++) begin
      x = big ? $urandom : ($urandom_range(0, 32'h7FFFF) - 32'h40000);
      v[e*32 +: 32] = x;
    end
    return v;
  endfunction

  // Monitor: pops one expectation per transfer and checks hold behaviour.
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk); #2;
      for (int k = 0; k < 3; k++) begin
        if (!rst) begin
          if (ov[k] && !ordy[k]) begin
            check("stall_in_ready", k, 32'(ir[k]), 32'd0);
            if (q_size(k) != 0) begin
              peek_exp(k, e);
              check("held_data", k, od[k], e);
            end
          end
          if (ov[k] && ordy[k]) begin
            if (q_size(k) == 0) begin
              n_checks++; n_err++;
              $display("FAIL unexpected_output u%0d: got %h expected none", k, od[k]);
            end else begin
              pop_exp(k, e);
              check("out_data", k, od[k], e);
            end
          end
        end
      end
    end
  end

  initial begin : rnd_stall
    forever begin
      @(negedge clk);
      if (rnd_stall_on)
        for (int k = 0; k < 3; k++) ordy[k] = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic rnd_driver(input int k);
    for (int p = 0; p < 15; p++) begin
      bit big = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < ch_of[k]; c++)
        drive_beat(k, rnd_vec(big), rnd_vec(big), rnd_vec(big)[31:0]);
      if ($urandom_range(0, 3) == 0) idle(k);
    end
    idle(k);
  endtask

  logic [DW-1:0] ones, halves, neg_ones, e0_one, big_pos, big_neg;

  initial begin : main
    ch_of   = '{1, 1, 3};
    relu_of = '{1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; wn[k] = '0; wt[k] = '0; bs[k] = '0; ordy[k] = 1'b1;
      m_acc[k] = 0; m_cnt[k] = 0; ovr_en[k] = 1'b0; ovr_val[k] = '0;
    end
    ones     = {N_EL{32'h00010000}};
    halves   = {N_EL{32'h00008000}};
    neg_ones = {N_EL{32'hFFFF0000}};
    big_pos  = {N_EL{32'h7FFF0000}};
    big_neg  = {N_EL{32'h80010000}};
    e0_one   = {{(N_EL-1){32'h0}}, 32'h00010000};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;

    // Basic pixel with latency: out_valid rises two edges after acceptance.
    ovr_en[0] = 1'b1; ovr_val[0] = 32'h0004C000;
    drive_beat(0, ones, halves, 32'h00004000);
    @(negedge clk); iv[0] = 1'b0; #2;
    check("lat_n0", 0, 32'(ov[0]), 32'd0);
    @(negedge clk); #2;
    check("lat_n1", 0, 32'(ov[0]), 32'd0);
    @(negedge clk); #2;
    check("lat_n2", 0, 32'(ov[0]), 32'd1);

    // ReLU on and off for a negative result.
    ovr_en[1] = 1'b1; ovr_val[1] = 32'h00000000;
    drive_beat(1, ones, neg_ones, 32'h0); idle(1);
    ovr_en[0] = 1'b1; ovr_val[0] = 32'hFFF70000;
    drive_beat(0, ones, neg_ones, 32'h0); idle(0);

    // Saturation at both rails.
    ovr_en[0] = 1'b1; ovr_val[0] = 32'h7FFFFFFF;
    drive_beat(0, big_pos, ones, 32'h7FFF0000);
    ovr_en[0] = 1'b1; ovr_val[0] = 32'h80000000;
    drive_beat(0, big_neg, ones, 32'h80010000); idle(0);

    // Three channels; bias on later beats must be ignored.
    ovr_en[2] = 1'b1; ovr_val[2] = 32'h00040000;
    drive_beat(2, ones, e0_one, 32'h00010000);
    drive_beat(2, ones, e0_one, 32'h00990000);
    drive_beat(2, ones, e0_one, 32'h00990000); idle(2);
    drain();

    // Backpressure: hold the first result for 5 cycles while 4 pixels stream.
    fork
      begin
        for (int p = 0; p < 4; p++) drive_beat(0, rnd_vec(1'b0), rnd_vec(1'b0), rnd_vec(1'b0)[31:0]);
        idle(0);
      end
      begin
        int cnt = 0;
        do begin @(negedge clk); cnt++; end while (!ov[0] && cnt < 50);
        check("bp_first_valid", 0, 32'(ov[0]), 32'd1);
        ordy[0] = 1'b0;
        repeat (5) @(negedge clk);
        ordy[0] = 1'b1;
        #2 check("bp_stream0", 0, 32'(ov[0]), 32'd1);
        for (int i = 1; i < 4; i++) begin
          @(negedge clk); #2;
          check("bp_no_bubble", 0, 32'(ov[0]), 32'd1);
        end
      end
    join
    drain();

    // Reset after the first of three channel beats discards the partial sum.
    drive_beat(2, ones, e0_one, 32'h00770000);
    @(negedge clk);
    iv[2] = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) m_cnt[k] = 0;
    #3 check_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    ovr_en[2] = 1'b1; ovr_val[2] = 32'h00040000;
    drive_beat(2, ones, e0_one, 32'h00010000);
    drive_beat(2, ones, e0_one, 32'h00990000);
    drive_beat(2, ones, e0_one, 32'h00990000); idle(2);
    drain();

    // Random traffic with random backpressure on all instances.
    rnd_stall_on = 1'b1;
    fork
      rnd_driver(0);
      rnd_driver(1);
      rnd_driver(2);
    join
    @(negedge clk);
    rnd_stall_on = 1'b0;
    for (int k = 0; k < 3; k++) ordy[k] = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
